// File: rtl/pie_cmd_encoder.sv
// Reader-side PIE command transmitter: delimiter, data-0, RTcal, optional TRcal,
// then MSB-first PIE data symbols, all timed in clk cycles.
module pie_cmd_encoder #(
  parameter int MAXLEN    = 64,
  parameter int TARI_CYC  = 8,
  parameter int DATA1_CYC = 16,
  parameter int PW_CYC    = 4,
  parameter int DELIM_CYC = 12,
  parameter int TRCAL_CYC = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              preamble_sel,
  input  logic [MAXLEN-1:0] cmd_data,
  input  logic [6:0]        cmd_len,
  input  logic              abort,
  output logic              pie_out,
  output logic              busy,
  output logic              done,
  output logic [6:0]        bit_idx
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RTCAL_CYC = TARI_CYC + DATA1_CYC;
  localparam int MAXP      = imax(imax(DELIM_CYC, RTCAL_CYC), imax(TRCAL_CYC, DATA1_CYC));
  localparam int TW        = imax(8, $clog2(MAXP + 1));

  localparam logic [TW-1:0] T_DELIM = TW'(DELIM_CYC - 1);
  localparam logic [TW-1:0] T_TARI  = TW'(TARI_CYC - 1);
  localparam logic [TW-1:0] T_DATA1 = TW'(DATA1_CYC - 1);
  localparam logic [TW-1:0] T_RTCAL = TW'(RTCAL_CYC - 1);
  localparam logic [TW-1:0] T_TRCAL = TW'(TRCAL_CYC - 1);
  localparam logic [TW-1:0] T_PW    = TW'(PW_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_DELIM, S_DATA0, S_RTCAL, S_TRCAL, S_BITS, S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_tmr, w_tmr_nxt;
  logic [MAXLEN-1:0] r_data;
  logic              r_pre;
  logic [6:0]        r_len, w_len_cap;
  logic [6:0]        r_bit_idx, w_bit_idx_nxt;
  logic              r_pie, r_busy, r_done;
  logic              w_pie_nxt, w_cap, w_shift, w_zero;
  logic [TW-1:0]     w_first_sym, w_next_sym;

  assign w_len_cap   = (int'(cmd_len) > MAXLEN) ? 7'(MAXLEN) : cmd_len;
  assign w_zero      = (r_tmr == '0);
  assign w_first_sym = r_data[MAXLEN-1] ? T_DATA1 : T_TARI;
  assign w_next_sym  = r_data[MAXLEN-2] ? T_DATA1 : T_TARI;

  always_comb begin
    w_state_nxt   = r_state;
    w_tmr_nxt     = r_tmr - 1'b1;
    w_bit_idx_nxt = r_bit_idx;
    w_cap         = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        w_state_nxt = S_IDLE;
        w_tmr_nxt   = r_tmr;
        if (start) begin
          w_cap         = 1'b1;
          w_state_nxt   = S_DELIM;
          w_tmr_nxt     = T_DELIM;
          w_bit_idx_nxt = '0;
        end
      end
      S_DELIM: if (w_zero) begin
        w_state_nxt = S_DATA0;
        w_tmr_nxt   = T_TARI;
      end
      S_DATA0: if (w_zero) begin
        w_state_nxt = S_RTCAL;
        w_tmr_nxt   = T_RTCAL;
      end
      S_RTCAL: if (w_zero) begin
        if (r_pre) begin
          w_state_nxt = S_TRCAL;
          w_tmr_nxt   = T_TRCAL;
        end else if (r_len == '0) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_BITS;
          w_tmr_nxt   = w_first_sym;
        end
      end
      S_TRCAL: if (w_zero) begin
        if (r_len == '0) begin
          w_state_nxt = S_FIN;
        end else begin
          w_state_nxt = S_BITS;
          w_tmr_nxt   = w_first_sym;
        end
      end
      S_BITS: if (w_zero) begin
        if (r_bit_idx == r_len - 7'd1) begin
          w_state_nxt = S_FIN;
        end else begin
          w_shift       = 1'b1;
          w_bit_idx_nxt = r_bit_idx + 7'd1;
          w_tmr_nxt     = w_next_sym;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt   = S_IDLE;
      w_tmr_nxt     = r_tmr;
      w_bit_idx_nxt = r_bit_idx;
      w_cap         = 1'b0;
      w_shift       = 1'b0;
    end
  end

  // Outputs are registered from the next state so each symbol's high phase
  // lasts while the remaining count is still above the pulse width.
  always_comb begin
    w_pie_nxt = 1'b1;
    case (w_state_nxt)
      S_DELIM:                          w_pie_nxt = 1'b0;
      S_DATA0, S_RTCAL, S_TRCAL, S_BITS: w_pie_nxt = (w_tmr_nxt >= T_PW);
      default:                          w_pie_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_pre     <= 1'b0;
      r_len     <= '0;
      r_bit_idx <= '0;
      r_pie     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmr     <= w_tmr_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_pie     <= w_pie_nxt;
      r_busy    <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
      r_done    <= (w_state_nxt == S_FIN);
      if (w_cap) begin
        r_pre <= preamble_sel;
        r_len <= w_len_cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap)
      r_data <= cmd_data;
    else if (w_shift)
      r_data <= {r_data[MAXLEN-2:0], 1'b0};
  end

  assign pie_out = r_pie;
  assign busy    = r_busy;
  assign done    = r_done;
  assign bit_idx = r_bit_idx;

endmodule

// File: tb/tb_pie_cmd_encoder.sv
// Bench for pie_cmd_encoder: expected envelope built as a list of symbols from
// the PIE timing rules, compared cycle by cycle against the DUT.
module tb_pie_cmd_encoder;
  localparam int MAXLEN = 64;
  localparam int TARI   = 8;
  localparam int D1     = 16;
  localparam int PW     = 4;
  localparam int DELIM  = 12;
  localparam int TRCAL  = 48;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              preamble_sel;
  logic [MAXLEN-1:0] cmd_data;
  logic [6:0]        cmd_len;
  logic              abort;
  logic              pie_out;
  logic              busy;
  logic              done;
  logic [6:0]        bit_idx;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_q[$];

  pie_cmd_encoder #(
    .MAXLEN(MAXLEN), .TARI_CYC(TARI), .DATA1_CYC(D1), .PW_CYC(PW),
    .DELIM_CYC(DELIM), .TRCAL_CYC(TRCAL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .preamble_sel(preamble_sel),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .abort(abort),
    .pie_out(pie_out), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sym(input int len);
    repeat (len - PW) exp_q.push_back(1'b1);
    repeat (PW) exp_q.push_back(1'b0);
  endtask

  task automatic build(input bit pre, input logic [MAXLEN-1:0] d, input int len);
    int n;
    n = (len > MAXLEN) ? MAXLEN : len;
    exp_q.delete();
    repeat (DELIM) exp_q.push_back(1'b0);
    sym(TARI);
    sym(TARI + D1);
    if (pre) sym(TRCAL);
    for (int i = 0; i < n; i++) sym(d[MAXLEN-1-i] ? D1 : TARI);
  endtask

  task automatic scramble();
    preamble_sel = 1'($urandom);
    cmd_data     = {$urandom, $urandom};
    cmd_len      = 7'($urandom);
  endtask

  task automatic launch(input bit pre, input logic [MAXLEN-1:0] d, input int len);
    preamble_sel = pre;
    cmd_data     = d;
    cmd_len      = 7'(len);
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic run_frame(input bit pre, input logic [MAXLEN-1:0] d, input int len,
                           input bit launched, input int spur, input int abort_at,
                           input bit chain, input bit npre, input logic [MAXLEN-1:0] nd,
                           input int nlen);
    int n;
    n = (len > MAXLEN) ? MAXLEN : len;
    build(pre, d, len);
    if (!launched) launch(pre, d, len);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("pie@%0d", i), pie_out, exp_q[i]);
      chk($sformatf("busy@%0d", i), busy, 1);
      chk($sformatf("done@%0d", i), done, 0);
      if (i == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_pie", pie_out, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (4) begin
          step();
          chk("post_abort_done", done, 0);
          chk("post_abort_pie", pie_out, 1);
        end
        return;
      end
      scramble();
      start = (i == spur);
      step();
      start = 1'b0;
    end
    chk("fin_pie", pie_out, 1);
    chk("fin_busy", busy, 0);
    chk("fin_done", done, 1);
    chk("fin_bit_idx", bit_idx, (n == 0) ? 0 : n - 1);
    if (chain) begin
      launch(npre, nd, nlen);
    end else begin
      step();
      chk("idle_done", done, 0);
      chk("idle_pie", pie_out, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [MAXLEN-1:0] d;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    scramble();
    repeat (3) step();
    chk("rst_pie", pie_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bit_idx", bit_idx, 0);
    reset = 1'b0;
    step();
    chk("idle_pie0", pie_out, 1);
    chk("idle_busy0", busy, 0);

    // Directed frames: frame-sync 1010, preamble 1010, empty, over-long
    d = '0;
    d[MAXLEN-1 -: 4] = 4'b1010;
    run_frame(1'b0, d, 4, 1'b0, -1, -1, 1'b0, 1'b0, '0, 0);
    run_frame(1'b1, d, 4, 1'b0, -1, -1, 1'b0, 1'b0, '0, 0);
    run_frame(1'b0, {$urandom, $urandom}, 0, 1'b0, -1, -1, 1'b0, 1'b0, '0, 0);
    run_frame(1'b1, {$urandom, $urandom}, 100, 1'b0, -1, -1, 1'b0, 1'b0, '0, 0);

    // Abort mid-BITS, then abort while idle
    run_frame(1'b0, d, 4, 1'b0, -1, 50, 1'b0, 1'b0, '0, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_pie", pie_out, 1);
    chk("idle_abort_busy", busy, 0);

    // Second start during busy must not disturb the frame
    run_frame(1'b0, {$urandom, $urandom}, 20, 1'b0, 30, -1, 1'b0, 1'b0, '0, 0);

    // Asynchronous reset in the middle of the delimiter
    launch(1'b0, d, 4);
    repeat (4) step();
    chk("pre_rst_pie", pie_out, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pie", pie_out, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_bit_idx", bit_idx, 0);
    #1 reset = 1'b0;
    step();
    for (int i = 0; i < 120; i++) begin
      chk($sformatf("post_rst_done@%0d", i), done, 0);
      step();
    end
    chk("post_rst_busy", busy, 0);

    // Back-to-back: new start in the done cycle
    begin
      logic [MAXLEN-1:0] d2;
      int l2;
      bit p2;
      d2 = {$urandom, $urandom};
      l2 = $urandom_range(1, 12);
      p2 = 1'($urandom);
      run_frame(1'b0, d, 4, 1'b0, -1, -1, 1'b1, p2, d2, l2);
      run_frame(p2, d2, l2, 1'b1, -1, -1, 1'b0, 1'b0, '0, 0);
    end

    // Randomised frames
    for (int f = 0; f < 8; f++) begin
      run_frame(1'($urandom), {$urandom, $urandom}, $urandom_range(0, 100), 1'b0,
                $urandom_range(0, 60), -1, 1'b0, 1'b0, '0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pie_cmd_encoder.md
Name: pie_cmd_encoder

Overview:
Reader-side PIE (pulse-interval encoding) command transmitter. It serialises a command word into the envelope waveform that the tag's demodulated input expects: delimiter, data-0, RTcal, an optional TRcal (preamble vs frame-sync), then PIE data symbols MSB-first. It drives the tag demodulator input in the tag-level testbench and the reader-emulator FPGA build. All timing is expressed in clk cycles.

Parameters:
MAXLEN, 64, width of cmd_data; longest command in bits
TARI_CYC, 8, data-0 symbol length in cycles
DATA1_CYC, 16, data-1 symbol length; legal range 1.5*TARI_CYC to 2*TARI_CYC
PW_CYC, 4, low-pulse width ending every symbol; PW_CYC < TARI_CYC
DELIM_CYC, 12, delimiter low time
TRCAL_CYC, 48, TRcal length; legal range 1.1 to 3 times RTcal (RTcal = TARI_CYC + DATA1_CYC)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only while busy=0
preamble_sel  input  1  1 = full preamble (with TRcal), 0 = frame-sync
cmd_data  input  MAXLEN  command bits, MSB-aligned (bit MAXLEN-1 is sent first)
cmd_len  input  7  number of bits to send
abort  input  1  synchronous abandon of the current frame
pie_out  output  1  envelope: 1 = carrier on, 0 = carrier off
busy  output  1  high from the cycle after start is accepted until frame end
done  output  1  one-cycle pulse when a frame completes normally
bit_idx  output  7  index of the data bit currently being sent (debug)

Behaviour:
- Reset values: pie_out=1, busy=0, done=0, bit_idx=0, FSM=IDLE.
- Asserting reset mid-frame returns all outputs to their reset values immediately, because reset is asynchronous. No done pulse is produced.
- All outputs are registered.
- Capture: when start=1 and busy=0 at edge k:
  - latch cmd_data, preamble_sel and len = min(cmd_len, MAXLEN);
  - busy=1 from cycle k+1.
- start while busy=1 is ignored. No queuing.
- FSM: IDLE -> DELIM -> DATA0 -> RTCAL -> [TRCAL if preamble_sel] -> BITS -> FIN -> IDLE.
- DELIM: pie_out=0 for DELIM_CYC cycles, starting cycle k+1.
- Symbol rule for DATA0, RTCAL, TRCAL and each bit: a symbol of length L is pie_out=1 for L-PW_CYC cycles, then pie_out=0 for PW_CYC cycles.
- Symbol lengths:
  - DATA0: L=TARI_CYC.
  - RTCAL: L=TARI_CYC+DATA1_CYC.
  - TRCAL: L=TRCAL_CYC.
  - BITS: data-0 -> L=TARI_CYC; data-1 -> L=DATA1_CYC.
- Bit order: bits are sent from latched index MAXLEN-1 downward, len bits total. bit_idx counts 0..len-1 and holds its last value until the next start.
- len=0: BITS is skipped and the frame consists of the delimiter plus frame-sync/preamble only.
- FIN (the single cycle after the last PW low cycle): pie_out=1, done=1, busy=0, FSM returns to IDLE. A start on that same edge is accepted, since busy=0 there.
- Total frame cycles (first delimiter cycle to last low cycle):
  - DELIM_CYC + TARI_CYC + RTcal + (preamble_sel ? TRCAL_CYC : 0) + sum of bit symbol lengths.
  - done is high exactly that many cycles after the first delimiter cycle.
- abort=1 in any non-IDLE state: next cycle pie_out=1, busy=0, no done pulse, FSM=IDLE. abort in IDLE has no effect. If abort and reset coincide, reset dominates.
- Symbol timer: one down-counter, 8 bits minimum, sized for the largest parameter; reloaded at each symbol boundary with no dead cycles between symbols.
- Inputs other than start/abort are don't-care while busy=1; changing them must not alter the frame in flight.

Test Plan:
- Reset: reset pulse mid-DELIM -> pie_out=1, busy=0, done=0 in the same cycle; no done pulse afterwards.
- Frame-sync, cmd_data MSBs=4'b1010, cmd_len=4, defaults:
  - low 12; high 4 / low 4; high 20 / low 4;
  - then bits 1,0,1,0 as high 12/low 4, high 4/low 4, high 12/low 4, high 4/low 4;
  - done 92 cycles after the first low; busy high for exactly 92 cycles.
- Preamble, same command -> identical to the frame-sync case with high 44 / low 4 inserted after RTcal; done at 140 cycles.
- cmd_len=0, preamble_sel=0 -> done at 44 cycles. cmd_len=100 with MAXLEN=64 -> exactly 64 data symbols sent.
- abort asserted mid-BITS -> pie_out=1 and busy=0 on the next cycle, no done. A second start pulse during busy is ignored: total frame length is unchanged.
- Back-to-back: start asserted in the done cycle -> a new delimiter starts on the next cycle, with no idle high gap beyond the FIN cycle.
